// File: rtl/uart_reg_pkg.sv
// Shared constants and state encoding for the UART register command controller.
package uart_reg_pkg;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_NAK = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    WRITE,
    READ,
    TX_REQ
  } state_t;

  // True in the states that are waiting for the next byte of a partial command.
  function automatic logic is_wait_state(input state_t s);
    return (s == W_ADDR) || (s == W_DATA) || (s == R_ADDR);
  endfunction

endpackage

// File: rtl/cmd_timeout_ctr.sv
// Saturating inter-byte timer; expire fires on the last allowed idle cycle.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module cmd_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] SAT  = '1;
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [W-1:0] timer;

  // Count idle cycles while running, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer <= '0;
    end else if (run && (timer != SAT)) begin
      timer <= timer + 1'b1;
    end
  end

  assign expire = ENABLED && run && !clear && (timer == LAST);

endmodule

// File: rtl/uart_reg_cmd_ctrl.sv
// Byte-stream command parser driving a 16x8 register file and a UART transmitter.
// Write: 'W', addr, data -> one-cycle write, optional ACK. Read: 'R', addr -> value returned.
module uart_reg_cmd_ctrl
  import uart_reg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter bit          WR_ACK         = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       rf_wr_en,
  output logic [3:0] rf_addr,
  output logic [7:0] rf_wr_data,
  input  logic [7:0] rf_rd_data,
  output logic       busy,
  output logic       rx_drop,
  output logic       cmd_timeout
);

  state_t     state, state_n;
  logic [3:0] addr_q, addr_n;
  logic [7:0] data_q, data_n;
  logic [7:0] tx_byte, tx_byte_n;
  logic       waiting;
  logic       expire;

  assign waiting = is_wait_state(state);

  cmd_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid || !waiting),
    .run    (waiting && !rx_valid),
    .expire (expire)
  );

  // State and command registers; reset discards any partial command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      tx_byte <= '0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      data_q  <= data_n;
      tx_byte <= tx_byte_n;
    end
  end

  // Next-state decode, register updates and strobe outputs.
  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    data_n      = data_q;
    tx_byte_n   = tx_byte;
    tx_start    = 1'b0;
    rf_wr_en    = 1'b0;
    rx_drop     = 1'b0;
    cmd_timeout = 1'b0;

    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR) begin
            state_n = W_ADDR;
          end else if (rx_data == CMD_RD) begin
            state_n = R_ADDR;
          end else begin
            tx_byte_n = RSP_NAK;
            state_n   = TX_REQ;
          end
        end
      end

      W_ADDR, R_ADDR: begin
        if (rx_valid) begin
          if (rx_data[7:4] != 4'h0) begin
            tx_byte_n = RSP_NAK;
            state_n   = TX_REQ;
          end else begin
            addr_n = rx_data[3:0];
            if (state == W_ADDR) begin
              state_n = W_DATA;
            end else begin
              state_n = READ;
            end
          end
        end else if (expire) begin
          cmd_timeout = 1'b1;
          state_n     = IDLE;
        end
      end

      W_DATA: begin
        if (rx_valid) begin
          data_n  = rx_data;
          state_n = WRITE;
        end else if (expire) begin
          cmd_timeout = 1'b1;
          state_n     = IDLE;
        end
      end

      WRITE: begin
        rf_wr_en = 1'b1;
        rx_drop  = rx_valid;
        if (WR_ACK) begin
          tx_byte_n = RSP_ACK;
          state_n   = TX_REQ;
        end else begin
          state_n = IDLE;
        end
      end

      READ: begin
        rx_drop   = rx_valid;
        tx_byte_n = rf_rd_data;
        state_n   = TX_REQ;
      end

      TX_REQ: begin
        rx_drop = rx_valid;
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_n  = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign rf_addr    = addr_q;
  assign rf_wr_data = data_q;
  assign tx_data    = tx_byte;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_reg_cmd_ctrl.sv
// Directed testbench for uart_reg_cmd_ctrl with a simple 16x8 register file attached.
module tb_uart_reg_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rf_wr_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_wr_data;
  logic [7:0] rf_rd_data;
  logic       busy;
  logic       rx_drop;
  logic       cmd_timeout;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int cyc = 0;
  int last_rx_cycle = 0;
  int tx_count = 0;
  int tx_cycle = 0;
  logic [7:0] last_tx = 8'h00;
  int wr_count = 0;
  int wr_cycle = 0;
  logic [3:0] wr_addr = 4'h0;
  logic [7:0] wr_data = 8'h00;
  int drop_count = 0;
  int to_count = 0;
  int to_cycle = 0;

  logic [7:0] mem [16];

  uart_reg_cmd_ctrl #(
    .TIMEOUT_CYCLES(16),
    .WR_ACK(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .rf_wr_en    (rf_wr_en),
    .rf_addr     (rf_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_rd_data  (rf_rd_data),
    .busy        (busy),
    .rx_drop     (rx_drop),
    .cmd_timeout (cmd_timeout)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write on the clock edge ending the write cycle.
  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
  end
  always @(posedge clk) if (rf_wr_en) mem[rf_addr] <= rf_wr_data;
  assign rf_rd_data = mem[rf_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (rx_valid) last_rx_cycle = cyc;
    if (tx_start) begin
      tx_count = tx_count + 1;
      tx_cycle = cyc;
      last_tx  = tx_data;
    end
    if (rf_wr_en) begin
      wr_count = wr_count + 1;
      wr_cycle = cyc;
      wr_addr  = rf_addr;
      wr_data  = rf_wr_data;
    end
    if (rx_drop) drop_count = drop_count + 1;
    if (cmd_timeout) begin
      to_count = to_count + 1;
      to_cycle = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one byte on the receive strobe for a single cycle.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    checkOutput(tag, {31'b0, busy}, 32'h0);
  endtask

  int strobe;
  int base_tx;
  int base_wr;
  int release_cycle;

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs",
                {7'b0, tx_start, tx_data, rf_wr_en, rf_addr, rf_wr_data, busy, rx_drop, cmd_timeout},
                32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write 0xA5 to register 3, expect ACK
    applyStimulus(8'h57);
    applyStimulus(8'h03);
    applyStimulus(8'hA5);
    strobe = last_rx_cycle;
    waitIdle("write_idle");
    checkOutput("write_count", wr_count, 1);
    checkOutput("write_addr", wr_addr, 4'h3);
    checkOutput("write_data", wr_data, 8'hA5);
    checkOutput("write_latency", wr_cycle - strobe, 1);
    checkOutput("ack_count", tx_count, 1);
    checkOutput("ack_data", last_tx, 8'h4B);

    // Read register 3 back
    applyStimulus(8'h52);
    applyStimulus(8'h03);
    strobe = last_rx_cycle;
    waitIdle("read_idle");
    checkOutput("read_addr", rf_addr, 4'h3);
    checkOutput("read_tx_count", tx_count, 2);
    checkOutput("read_latency", tx_cycle - strobe, 2);
    checkOutput("read_data", last_tx, 8'hA5);
    checkOutput("read_no_write", wr_count, 1);

    // Bad command byte, then a read with an out-of-range address
    applyStimulus(8'h00);
    waitIdle("badcmd_idle");
    checkOutput("badcmd_count", tx_count, 3);
    checkOutput("badcmd_nak", last_tx, 8'h3F);
    applyStimulus(8'h52);
    applyStimulus(8'h13);
    waitIdle("badaddr_idle");
    checkOutput("badaddr_count", tx_count, 4);
    checkOutput("badaddr_nak", last_tx, 8'h3F);
    applyStimulus(8'h52);
    applyStimulus(8'h03);
    waitIdle("reread_idle");
    checkOutput("reread_data", last_tx, 8'hA5);
    checkOutput("nak_no_write", wr_count, 1);

    // Abandoned write command times out after 16 idle cycles
    base_tx = tx_count;
    applyStimulus(8'h57);
    strobe = last_rx_cycle;
    repeat (13) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_not_early", to_count, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("timeout_count", to_count, 1);
    checkOutput("timeout_latency", to_cycle - strobe, 16);
    checkOutput("timeout_idle", {31'b0, busy}, 32'h0);
    checkOutput("timeout_no_tx", tx_count, base_tx);
    applyStimulus(8'h52);
    applyStimulus(8'h00);
    waitIdle("reg0_idle");
    checkOutput("reg0_data", last_tx, 8'h00);

    // Write 0x3C to register 7, then read it with the transmitter held busy
    applyStimulus(8'h57);
    applyStimulus(8'h07);
    applyStimulus(8'h3C);
    waitIdle("w7_idle");
    base_tx = tx_count;
    tx_busy = 1'b1;
    applyStimulus(8'h52);
    applyStimulus(8'h07);
    applyStimulus(8'h57);
    checkOutput("drop_count", drop_count, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_defer", tx_count, base_tx);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    release_cycle = cyc;
    waitIdle("busy_idle");
    checkOutput("busy_tx_count", tx_count, base_tx + 1);
    checkOutput("busy_tx_cycle", tx_cycle, release_cycle);
    checkOutput("busy_tx_data", last_tx, 8'h3C);

    // Reset in the middle of a write command
    base_wr = wr_count;
    base_tx = tx_count;
    applyStimulus(8'h57);
    applyStimulus(8'h05);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_outputs",
                {7'b0, tx_start, tx_data, rf_wr_en, rf_addr, rf_wr_data, busy, rx_drop, cmd_timeout},
                32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset_no_write", wr_count, base_wr);
    checkOutput("midreset_no_tx", tx_count, base_tx);
    applyStimulus(8'h52);
    applyStimulus(8'h05);
    waitIdle("reg5_idle");
    checkOutput("reg5_data", last_tx, 8'h00);
    checkOutput("reg5_tx_count", tx_count, base_tx + 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_cmd_ctrl.md
Name: uart_reg_cmd_ctrl

Overview:
Command controller between the UART byte receiver/transmitter and the 16x8 register file. It parses a byte-stream protocol: write is 'W', addr, data; read is 'R', addr. It then drives a one-cycle register-file write, or performs a register-file read and returns the value over UART TX. It also generates ACK/NAK response bytes, discards stale partial commands on inter-byte timeout, and flags bytes dropped while busy.

Parameters:
TIMEOUT_CYCLES, 1000000, max clk cycles between bytes of one command before abort; 0 disables timeout
WR_ACK, 1, 1 = send ACK byte 0x4B after each write; 0 = silent write

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rx_data  input  8  received byte, valid only when rx_valid=1
rx_valid  input  1  one-cycle strobe per received byte
tx_busy  input  1  transmitter busy; asserts the cycle after tx_start and stays high until the byte is sent
tx_start  output  1  one-cycle strobe to launch tx_data
tx_data  output  8  byte to transmit, held stable from tx_start until the next tx_start
rf_wr_en  output  1  register-file write enable, one-cycle pulse
rf_addr  output  4  register-file address (registered)
rf_wr_data  output  8  register-file write data (registered)
rf_rd_data  input  8  register-file combinational read data for rf_addr
busy  output  1  1 whenever state != IDLE
rx_drop  output  1  one-cycle pulse when rx_valid arrives in WRITE, READ or TX_REQ (byte discarded)
cmd_timeout  output  1  one-cycle pulse when a partial command is aborted by timeout

Behaviour:
- Reset: state=IDLE; addr_q=0, data_q=0, tx_byte=0, timer=0. All outputs 0, including rf_addr=0, rf_wr_data=0 and tx_data=0. Reset mid-command discards the command; no write or TX is issued.
- Constants: CMD_WR=0x57, CMD_RD=0x52, RSP_ACK=0x4B, RSP_NAK=0x3F.
- rf_addr is always addr_q. rf_wr_data is always data_q. tx_data is always tx_byte.
- State IDLE:
  - rx_valid with CMD_WR -> W_ADDR.
  - rx_valid with CMD_RD -> R_ADDR.
  - rx_valid with any other byte -> tx_byte=RSP_NAK, go to TX_REQ.
- State W_ADDR / R_ADDR, on rx_valid:
  - If rx_data[7:4] != 0: tx_byte=RSP_NAK, go to TX_REQ.
  - Otherwise addr_q=rx_data[3:0], then W_ADDR -> W_DATA and R_ADDR -> READ.
- State W_DATA: on rx_valid, data_q=rx_data, go to WRITE.
- State WRITE: rf_wr_en=1 for exactly this cycle, using addr_q/data_q. Then, if WR_ACK=1, tx_byte=RSP_ACK and go to TX_REQ; otherwise go to IDLE.
- State READ: tx_byte=rf_rd_data, sampled this cycle at rf_addr=addr_q. Go to TX_REQ.
- State TX_REQ:
  - Stays while tx_busy=1.
  - With tx_busy=0: tx_start=1 for one cycle, then go to IDLE.
- Latency, last-byte strobe to rf_wr_en: 1 cycle.
- Latency, read-address strobe to tx_start: 2 cycles when tx_busy=0.
- Timeout:
  - timer clears on every rx_valid and in every state other than W_ADDR, W_DATA, R_ADDR.
  - In those three states, timer increments each cycle without rx_valid.
  - When timer == TIMEOUT_CYCLES-1 with no rx_valid: cmd_timeout=1, state -> IDLE, no NAK sent.
  - If rx_valid arrives in the same cycle, the byte wins and there is no timeout.
  - Timer width is $clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- rx_valid in WRITE, READ or TX_REQ: the byte is ignored and rx_drop=1 for that cycle; the state transition is unaffected.
- Same-address read after write sees the new value (register file writes on the edge ending WRITE).

Decomposition:
- Shared package uart_reg_pkg holds:
  - CMD_WR, CMD_RD, RSP_ACK, RSP_NAK byte constants;
  - the state enum typedef (IDLE, W_ADDR, W_DATA, R_ADDR, WRITE, READ, TX_REQ).
- One natural sub-module: cmd_timeout_ctr. It is the parameterised saturating inter-byte timer with inputs clear/run and output expire.
- All other logic (FSM, address/data/response registers) lives in the top module.

Test Plan:
- Write 0x57,0x03,0xA5 with tx_busy=0 -> rf_wr_en high exactly 1 cycle with rf_addr=3, rf_wr_data=0xA5; then tx_start with tx_data=0x4B; busy falls after.
- Read 0x52,0x03 after the above write -> rf_addr=3, tx_start 2 cycles after the address strobe with tx_data=0xA5; no rf_wr_en pulse.
- Bad command 0x00, then bad address 0x52,0x13 -> two tx_start pulses, each with tx_data=0x3F; register 3 unchanged (verified by a read returning 0xA5).
- TIMEOUT_CYCLES=16: send 0x57 then idle 16 cycles -> cmd_timeout pulse, state IDLE, no tx_start. Then 0x52,0x00 -> tx_data=0x00 (reset value).
- Hold tx_busy=1 during read response and inject rx_valid in TX_REQ -> rx_drop pulse, tx_start deferred until the cycle tx_busy=0, tx_data=correct register value.
- Assert rst after 0x57,0x05 (before the data byte) -> no write; all outputs 0; subsequent read 0x52,0x05 returns 0x00.
